// File: rtl/fft_pkg.sv
// Shared constants and collector state encoding for the FFT source/sink blocks.
// No logic; compile-time definitions only.
// Imported by the source-side collector, its magnitude stage and the sink-side loader.
package fft_pkg;

   localparam int FFT_N     = 512;
   localparam int ADDR_BITS = 9;
   localparam int DATA_BITS = 8;
   localparam int EXP_BITS  = 6;
   localparam int MAG_BITS  = 2*DATA_BITS + 1;

   // Index of the final bin in a frame; eop is expected exactly here.
   localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(FFT_N - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOP = 2'd1,
      COLLECT  = 2'd2,
      FINISH   = 2'd3
   } collector_state_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Squared magnitude re^2+im^2 of a signed complex sample, with a travelling valid bit.
// Latency: 1 cycle (result and valid registered together).
// No backpressure: a new sample may be presented every cycle.
module fft_mag_sq
   import fft_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid,
   input  logic signed [DATA_BITS-1:0] re,
   input  logic signed [DATA_BITS-1:0] im,
   output logic                        mag_valid,
   output logic [MAG_BITS-1:0]         mag
);

   logic signed [2*DATA_BITS-1:0] re_x, im_x;
   logic signed [2*DATA_BITS-1:0] re_sq, im_sq;

   // Sign-extend before squaring so the full-width product is exact; the
   // largest square (-128)^2 = 16384 still fits as a positive 16-bit value.
   assign re_x  = {{DATA_BITS{re[DATA_BITS-1]}}, re};
   assign im_x  = {{DATA_BITS{im[DATA_BITS-1]}}, im};
   assign re_sq = re_x * re_x;
   assign im_sq = im_x * im_x;

   // Register the unsigned sum; the extra MSB absorbs 16384+16384 = 32768.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mag_valid <= 1'b0;
         mag       <= '0;
      end else begin
         mag_valid <= valid;
         mag       <= {1'b0, re_sq} + {1'b0, im_sq};
      end
   end

endmodule

// File: rtl/fft_source_collector.sv
// Drains one FFT output frame per arm: writes |X|^2 per bin to RAM, tracks peak, latches exponent.
// Latency: bin write 1 cycle after beat acceptance; done 1 cycle after the final write.
// Backpressure: source_ready high only in WAIT_SOP/COLLECT. Macro FFT_BITREV_EN bit-reverses bin_addr.
module fft_source_collector
   import fft_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 arm,
   input  logic                 source_valid,
   input  logic                 source_sop,
   input  logic                 source_eop,
   input  logic [DATA_BITS-1:0] source_real,
   input  logic [DATA_BITS-1:0] source_imag,
   input  logic [EXP_BITS-1:0]  source_exp,
   input  logic [1:0]           source_error,
   output logic                 source_ready,
   output logic [ADDR_BITS-1:0] bin_addr,
   output logic [MAG_BITS-1:0]  bin_data,
   output logic                 bin_wren,
   output logic [ADDR_BITS-1:0] peak_bin,
   output logic [MAG_BITS-1:0]  peak_mag,
   output logic [EXP_BITS-1:0]  frame_exp,
   output logic                 done,
   output logic                 frame_err
);

   collector_state_t     state, state_nxt;
   logic [ADDR_BITS-1:0] idx;        // index the next non-sop beat will take
   logic [ADDR_BITS-1:0] beat_idx;   // index of the beat being accepted this cycle
   logic [ADDR_BITS-1:0] wr_addr;    // RAM address for that beat
   logic [ADDR_BITS-1:0] addr_q;
   logic                 use_beat;   // beat accepted and belongs to the frame
   logic                 beat_first; // beat starts (or restarts) the frame
   logic                 last_beat;
   logic                 err_set;
   logic                 first_q;
   logic                 mag_vld;
   logic [MAG_BITS-1:0]  mag;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state, ready, and classification of the current beat.
   always_comb begin
      state_nxt    = state;
      source_ready = 1'b0;
      use_beat     = 1'b0;
      beat_first   = 1'b0;
      beat_idx     = idx;
      last_beat    = 1'b0;
      err_set      = 1'b0;
      case (state)
         IDLE: begin
            if (arm) state_nxt = WAIT_SOP;
         end
         WAIT_SOP: begin
            source_ready = 1'b1;
            // Non-sop beats are drained silently while hunting for a frame start.
            use_beat     = source_valid && source_sop;
         end
         COLLECT: begin
            source_ready = 1'b1;
            use_beat     = source_valid;
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (use_beat) begin
         beat_first = source_sop;
         beat_idx   = source_sop ? '0 : idx;
         last_beat  = (beat_idx == LAST_IDX);
         // Errors: core-reported error, sop restart mid-frame, eop off the
         // last bin, or the last bin reached without eop.
         err_set    = (source_error != 2'b00)
                   || (source_sop && (state == COLLECT))
                   || (source_eop != last_beat);
         state_nxt  = source_eop ? FINISH : COLLECT;
      end
   end

   // Map the natural bin index to the RAM address.
   always_comb begin
      wr_addr = beat_idx;
`ifdef FFT_BITREV_EN
      for (int b = 0; b < ADDR_BITS; b++) begin
         wr_addr[b] = beat_idx[ADDR_BITS-1-b];
      end
`endif
   end

   fft_mag_sq u_mag_sq (
      .clk       (clk),
      .rst       (rst),
      .valid     (use_beat),
      .re        (source_real),
      .im        (source_imag),
      .mag_valid (mag_vld),
      .mag       (mag)
   );

   assign bin_wren = mag_vld;
   assign bin_data = mag;
   assign bin_addr = addr_q;

   // Frame bookkeeping: index, exponent, sticky error, write address pipeline, peak, done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx       <= '0;
         addr_q    <= '0;
         first_q   <= 1'b0;
         frame_exp <= '0;
         frame_err <= 1'b0;
         peak_bin  <= '0;
         peak_mag  <= '0;
         done      <= 1'b0;
      end else begin
         // Registered from FINISH so the pulse lands after the final write.
         done <= (state == FINISH);
         if ((state == IDLE) && arm) begin
            idx       <= '0;
            frame_err <= 1'b0;
            peak_bin  <= '0;
            peak_mag  <= '0;
         end
         if (use_beat) begin
            idx     <= beat_idx + ADDR_BITS'(1);
            addr_q  <= wr_addr;
            first_q <= beat_first;
            if (beat_first) frame_exp <= source_exp;
            if (err_set)    frame_err <= 1'b1;
         end
         // The first beat of a frame always loads; later ties keep the lower bin.
         if (mag_vld && (first_q || (mag > peak_mag))) begin
            peak_mag <= mag;
            peak_bin <= addr_q;
         end
      end
   end

endmodule
